pb_event_ctrl: RTL and testbench
================================

// Module: pb_event_ctrl
// PURPOSE
//  Multi-button front end for the GPIO peripheral: synchronises NUM_PB raw push-buttons, debounces
//  each with a per-button idle/wait1/one/wait0 FSM clocked by one shared sample tick, and
//  arbitrates the resulting press/release/long events round-robin into a small FIFO.
//  Software or the bus-side register block drains events over a valid/ready port.
// PARAMETERS
//  NUM_PB      4      number of buttons (2..8)
//  PRESCALE    50000  clk cycles per sample tick (>= NUM_PB+2)
//  STABLE_CNT  20     consecutive stable ticks required to accept an edge (>= 2)
//  LONG_CNT    1000   ticks held in ONE before a long-press event (> STABLE_CNT)
//  FIFO_DEPTH  4      event FIFO entries (power of 2)
// PORTS
//  clk          in   1                  system clock
//  resetn       in   1                  async active-low reset
//  pb_in        in   NUM_PB             raw button levels, asynchronous, active high
//  pb_level     out  NUM_PB             debounced level: 1 in ONE or WAIT0
//  evt_valid    out  1                  FIFO head holds an event
//  evt_ready    in   1                  consumer accepts head this cycle
//  evt_id       out  $clog2(NUM_PB)     button index of head event
//  evt_type     out  2                  01 press, 10 release, 11 long; 00 never emitted
//  evt_overflow out  1                  sticky: an event was lost
//  ovf_clr      in   1                  clears evt_overflow (set wins if same cycle)
// BEHAVIOUR
//  - Reset: all outputs 0, FSMs IDLE, counters 0, FIFO empty, RR pointer 0, prescaler 0.
//  - pb_in passes a 2-FF synchroniser (sync); the FSMs see only sync.
//  - Prescaler counts 0..PRESCALE-1; tick asserts for one cycle when the count is PRESCALE-1, then wraps.
//  - FSMs update only on tick; cnt is per-button, $clog2(LONG_CNT+1) bits, saturating:
//    IDLE : sync=1 -> WAIT1, cnt=1.
//    WAIT1: sync=0 -> IDLE; sync=1 & cnt==STABLE_CNT-1 -> ONE, cnt=0, raise press;
//           otherwise cnt++.
//    ONE  : sync=0 -> WAIT0, hold=cnt kept; sync=1 -> cnt++ (saturate at LONG_CNT), raise long once
//           when cnt reaches LONG_CNT-1.
//    WAIT0: sync=1 -> ONE (no event, long count resumes); sync=0 for STABLE_CNT consecutive ticks
//           -> IDLE, raise release. Uses a separate per-button release counter.
//  - Raised events set pend[i] and pend_type[i] at the tick edge.
//  - Arbiter: each cycle, if FIFO not full, grants the lowest pend index at or after the RR pointer
//    (wrapping). Write {i,type}, clear pend[i], pointer <- i+1 mod NUM_PB. One grant per cycle.
//  - Latency: lone event, empty FIFO -> evt_valid high 2 clk after the tick edge (grant, then FIFO
//    first-word fall-through).
//  - Handshake: a pop occurs when evt_valid & evt_ready. Head fields are stable while valid & !ready.
//    Full is registered; a pop and push in the same cycle while full are not allowed (push waits).
//  - Overflow: a new event for button i while pend[i]=1 drops the new event and sets evt_overflow.
//    FIFO full never drops; events stay pending.
//  - Simultaneous tick events on all NUM_PB buttons are all queued, in RR order, within NUM_PB cycles.
//  - resetn low at any time returns everything to reset state immediately, including the FIFO.
// CONFIGURATION
//  PB_LONGPRESS_EN defined: long event (11) generated as above.
//  PB_LONGPRESS_EN undefined: no long logic. The ONE counter is removed; evt_type is never 11.
// STRUCTURE
//  Shared package pb_ctrl_pkg: FSM state encoding (IDLE=00, WAIT1=01, ONE=10, WAIT0=11) and
//  evt_type constants EVT_PRESS/EVT_RELEASE/EVT_LONG.
//  Sub-module pb_evt_fifo:
//    - synchronous FWFT FIFO, width $clog2(NUM_PB)+2, depth FIFO_DEPTH;
//    - ports wr_en, wr_data, full, rd_en, rd_data, empty.
//  Synchroniser, prescaler, FSM array and arbiter are in pb_event_ctrl.
// TESTING
//  Sim parameters: PRESCALE=4, STABLE_CNT=3, LONG_CNT=8, NUM_PB=4, FIFO_DEPTH=4.
//  1. pb_in[2] high 40 clk, evt_ready=1 -> one press id=2; pb_level[2]=1; then low 40 clk -> one release.
//  2. pb_in[0] toggles every 3 clk for 60 clk -> no events; pb_level stays 0.
//  3. pb_in[1] held 60 clk (PB_LONGPRESS_EN) -> press then long id=1. Without the macro: press only.
//  4. All four buttons pressed in same cycle, evt_ready=0 -> 4 events, ids 0,1,2,3; valid held.
//  5. FIFO full, evt_ready=0, extra press then release on button 3 -> evt_overflow=1. ovf_clr -> 0.
//  6. resetn pulsed low with 2 events queued -> evt_valid=0 and pb_level=0 immediately.

Source files
------------

// File: rtl/pb_ctrl_pkg.sv
// Shared definitions for the push-button event controller: debounce FSM
// state encoding and event type codes.
package pb_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WAIT1 = 2'b01,
      ST_ONE   = 2'b10,
      ST_WAIT0 = 2'b11
   } pb_state_t;

   localparam logic [1:0] EVT_NONE    = 2'b00;
   localparam logic [1:0] EVT_PRESS   = 2'b01;
   localparam logic [1:0] EVT_RELEASE = 2'b10;
   localparam logic [1:0] EVT_LONG    = 2'b11;

endpackage

// File: rtl/pb_evt_fifo.sv
// First-word fall-through event FIFO: storage array feeding a registered head,
// so a word written into an empty FIFO is presented one cycle after the write.
module pb_evt_fifo #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic [CW-1:0]    mcnt, mcnt_nx;
   logic             hd_vld, hd_vld_nx;
   logic [WIDTH-1:0] hd;
   logic             push, pop, load;

   always_comb begin
      push      = wr_en & ~full;
      pop       = rd_en & hd_vld;
      load      = (mcnt != '0) & (~hd_vld | pop);
      mcnt_nx   = mcnt + CW'(push) - CW'(load);
      hd_vld_nx = load | (hd_vld & ~pop);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wr_data;
   end

   // full counts the head register too, so capacity is exactly DEPTH words
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr   <= '0;
         rptr   <= '0;
         mcnt   <= '0;
         hd_vld <= 1'b0;
         hd     <= '0;
         full   <= 1'b0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (load) begin
            hd   <= mem[rptr];
            rptr <= rptr + 1'b1;
         end
         mcnt   <= mcnt_nx;
         hd_vld <= hd_vld_nx;
         full   <= (mcnt_nx + CW'(hd_vld_nx)) == CW'(DEPTH);
      end
   end

   assign rd_data = hd;
   assign empty   = ~hd_vld;

endmodule

// File: rtl/pb_event_ctrl.sv
// Multi-button debouncer with round-robin event arbitration into a FWFT FIFO.
// Define PB_LONGPRESS_EN to enable long-press (type 11) events.
module pb_event_ctrl #(
   parameter int unsigned NUM_PB     = 4,
   parameter int unsigned PRESCALE   = 50000,
   parameter int unsigned STABLE_CNT = 20,
   parameter int unsigned LONG_CNT   = 1000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic [NUM_PB-1:0]         pb_in,
   output logic [NUM_PB-1:0]         pb_level,
   output logic                      evt_valid,
   input  logic                      evt_ready,
   output logic [$clog2(NUM_PB)-1:0] evt_id,
   output logic [1:0]                evt_type,
   output logic                      evt_overflow,
   input  logic                      ovf_clr
);
   import pb_ctrl_pkg::*;

   localparam int unsigned IW = $clog2(NUM_PB);
   localparam int unsigned CW = $clog2(LONG_CNT + 1);
   localparam int unsigned RW = $clog2(STABLE_CNT + 1);
   localparam int unsigned PW = $clog2(PRESCALE);

   logic [NUM_PB-1:0] s1, s2;
   logic [PW-1:0]     pcnt;
   logic              tick;

   pb_state_t         st     [NUM_PB];
   pb_state_t         st_nx  [NUM_PB];
   logic [CW-1:0]     cnt    [NUM_PB];
   logic [CW-1:0]     cnt_nx [NUM_PB];
   logic [RW-1:0]     rcnt   [NUM_PB];
   logic [RW-1:0]     rcnt_nx[NUM_PB];
   logic [NUM_PB-1:0] raise;
   logic [1:0]        rtype  [NUM_PB];

   logic [NUM_PB-1:0] pend, gsel, drop, accept;
   logic [1:0]        ptype  [NUM_PB];
   logic [IW-1:0]     rr, gnt_idx, idx;
   logic [IW:0]       sum;
   logic              gnt, full, empty;
   logic [IW+1:0]     wr_data, rd_data;

   assign tick = (pcnt == PW'(PRESCALE - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1   <= '0;
         s2   <= '0;
         pcnt <= '0;
      end else begin
         s1   <= pb_in;
         s2   <= s1;
         pcnt <= tick ? '0 : pcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned i = 0; i < NUM_PB; i++) begin
            st[i]   <= ST_IDLE;
            cnt[i]  <= '0;
            rcnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_PB; i++) begin
            st[i]   <= st_nx[i];
            cnt[i]  <= cnt_nx[i];
            rcnt[i] <= rcnt_nx[i];
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_PB; i++) begin
         st_nx[i]   = st[i];
         cnt_nx[i]  = cnt[i];
         rcnt_nx[i] = rcnt[i];
         raise[i]   = 1'b0;
         rtype[i]   = EVT_NONE;
         if (tick) begin
            case (st[i])
               ST_IDLE: begin
                  if (s2[i]) begin
                     st_nx[i]  = ST_WAIT1;
                     cnt_nx[i] = CW'(1);
                  end
               end
               ST_WAIT1: begin
                  if (!s2[i]) begin
                     st_nx[i]  = ST_IDLE;
                     cnt_nx[i] = '0;
                  end else if (cnt[i] == CW'(STABLE_CNT - 1)) begin
                     st_nx[i]  = ST_ONE;
                     cnt_nx[i] = '0;
                     raise[i]  = 1'b1;
                     rtype[i]  = EVT_PRESS;
                  end else begin
                     cnt_nx[i] = cnt[i] + 1'b1;
                  end
               end
               ST_ONE: begin
                  if (!s2[i]) begin
                     st_nx[i]   = ST_WAIT0;
                     rcnt_nx[i] = RW'(1);
                  end
`ifdef PB_LONGPRESS_EN
                  else if (cnt[i] != CW'(LONG_CNT)) begin
                     cnt_nx[i] = cnt[i] + 1'b1;
                     if (cnt[i] == CW'(LONG_CNT - 2)) begin
                        raise[i] = 1'b1;
                        rtype[i] = EVT_LONG;
                     end
                  end
`endif
               end
               ST_WAIT0: begin
                  if (s2[i]) begin
                     st_nx[i]   = ST_ONE;
                     rcnt_nx[i] = '0;
                  end else if (rcnt[i] == RW'(STABLE_CNT - 1)) begin
                     st_nx[i]   = ST_IDLE;
                     rcnt_nx[i] = '0;
                     cnt_nx[i]  = '0;
                     raise[i]   = 1'b1;
                     rtype[i]   = EVT_RELEASE;
                  end else begin
                     rcnt_nx[i] = rcnt[i] + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_PB; i++)
         pb_level[i] = (st[i] == ST_ONE) || (st[i] == ST_WAIT0);
   end

   // Round-robin search starting at rr, wrapping modulo NUM_PB
   always_comb begin
      gnt     = 1'b0;
      gnt_idx = '0;
      gsel    = '0;
      sum     = '0;
      idx     = '0;
      for (int unsigned k = 0; k < NUM_PB; k++) begin
         sum = {1'b0, rr} + (IW+1)'(k);
         if (sum >= (IW+1)'(NUM_PB)) sum = sum - (IW+1)'(NUM_PB);
         idx = sum[IW-1:0];
         if (!full && !gnt && pend[idx]) begin
            gnt     = 1'b1;
            gnt_idx = idx;
         end
      end
      if (gnt) gsel[gnt_idx] = 1'b1;
      drop    = raise & pend & ~gsel;
      accept  = raise & ~drop;
      wr_data = {gnt_idx, ptype[gnt_idx]};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend         <= '0;
         rr           <= '0;
         evt_overflow <= 1'b0;
         for (int unsigned i = 0; i < NUM_PB; i++) ptype[i] <= EVT_NONE;
      end else begin
         pend <= (pend & ~gsel) | accept;
         for (int unsigned i = 0; i < NUM_PB; i++)
            if (accept[i]) ptype[i] <= rtype[i];
         if (|drop)        evt_overflow <= 1'b1;
         else if (ovf_clr) evt_overflow <= 1'b0;
         if (gnt) rr <= (gnt_idx == IW'(NUM_PB - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   pb_evt_fifo #(
      .WIDTH (IW + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (gnt),
      .wr_data (wr_data),
      .full    (full),
      .rd_en   (evt_ready),
      .rd_data (rd_data),
      .empty   (empty)
   );

   assign evt_valid = ~empty;
   assign evt_id    = rd_data[IW+1:2];
   assign evt_type  = rd_data[1:0];

endmodule

// File: tb/tb_pb_event_ctrl.sv
// Scoreboard bench for pb_event_ctrl: a tick-level debounce model predicts events,
// a monitor matches every accepted FIFO word against the expected queue.
module tb_pb_event_ctrl;

   localparam int unsigned NPB = 4;
   localparam int unsigned PRE = 4;
   localparam int unsigned STB = 3;
   localparam int unsigned LNG = 8;
   localparam int unsigned DEP = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] pb_in = '0;
   logic [3:0] pb_level;
   logic       evt_valid;
   logic       evt_ready = 1'b0;
   logic [1:0] evt_id;
   logic [1:0] evt_type;
   logic       evt_overflow;
   logic       ovf_clr = 1'b0;

   pb_event_ctrl #(
      .NUM_PB     (NPB),
      .PRESCALE   (PRE),
      .STABLE_CNT (STB),
      .LONG_CNT   (LNG),
      .FIFO_DEPTH (DEP)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .pb_in        (pb_in),
      .pb_level     (pb_level),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_id       (evt_id),
      .evt_type     (evt_type),
      .evt_overflow (evt_overflow),
      .ovf_clr      (ovf_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (per-tick debounce rules) ----------------
   typedef struct { int id; int typ; } ev_t;
   ev_t  exp_q[$];
   int   got_ids[$];
   bit   chk_en = 1'b0;
   bit   [3:0] h1, h2, samp, m_lvl, m_pend;
   int   hi_run[NPB], lo_run[NPB], held[NPB];
   int   pc, inflight, emitted;
   bit   ovf_exp, drop_now, tick;

   task automatic emit(input int i, input int t);
      emitted++;
      if (inflight < DEP) begin
         inflight++;
         exp_q.push_back('{i, t});
      end else if (m_pend[i]) begin
         ovf_exp  = 1'b1;
         drop_now = 1'b1;
      end else begin
         m_pend[i] = 1'b1;
         exp_q.push_back('{i, t});
      end
   endtask

   always @(posedge clk) begin
      if (!resetn) begin
         h1 = '0; h2 = '0; m_lvl = '0; m_pend = '0;
         pc = 0; inflight = 0; ovf_exp = 1'b0;
         for (int i = 0; i < NPB; i++) begin hi_run[i] = 0; lo_run[i] = 0; held[i] = 0; end
         exp_q.delete();
      end else begin
         drop_now = 1'b0;
         tick = (pc == PRE - 1);
         pc   = tick ? 0 : pc + 1;
         samp = h2; h2 = h1; h1 = pb_in;
         if (tick) begin
            for (int i = 0; i < NPB; i++) begin
               if (!m_lvl[i]) begin
                  if (samp[i]) begin
                     hi_run[i]++;
                     if (hi_run[i] == STB) begin
                        m_lvl[i] = 1'b1; held[i] = 0; lo_run[i] = 0;
                        emit(i, 1);
                     end
                  end else hi_run[i] = 0;
               end else begin
                  if (samp[i]) begin
                     if (lo_run[i] == 0 && held[i] < LNG) begin
                        held[i]++;
`ifdef PB_LONGPRESS_EN
                        if (held[i] == LNG - 1) emit(i, 3);
`endif
                     end
                     lo_run[i] = 0;
                  end else begin
                     lo_run[i]++;
                     if (lo_run[i] == STB) begin
                        m_lvl[i] = 1'b0; hi_run[i] = 0;
                        emit(i, 2);
                     end
                  end
               end
            end
         end
         if (!drop_now && ovf_clr) ovf_exp = 1'b0;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("pb_level", pb_level, m_lvl);
         check("evt_overflow", evt_overflow, ovf_exp);
         if (evt_valid && evt_ready) begin
            int k;
            k = -1;
            for (int j = 0; j < exp_q.size(); j++)
               if (k < 0 && exp_q[j].id == int'(evt_id)) k = j;
            if (k < 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: actual id=%0d type=%0d expected none at %0t",
                        evt_id, evt_type, $time);
            end else begin
               check("evt_type", evt_type, exp_q[k].typ);
               exp_q.delete(k);
            end
            got_ids.push_back(int'(evt_id));
            if (inflight > 0) inflight--;
            for (int j = 0; j < NPB; j++)
               if (m_pend[j] && inflight < DEP) begin m_pend[j] = 1'b0; inflight++; end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      resetn = 1'b0; chk_en = 1'b0; pb_in = '0; evt_ready = 1'b0;
      step(3);
      resetn = 1'b1; chk_en = 1'b1;
      got_ids.delete();
      step(2);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || evt_valid) && n < 300) begin @(negedge clk); n++; end
      check(name, exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, n;
      resetn = 1'b0;
      step(3);
      check("rst_valid", evt_valid, 0);
      check("rst_level", pb_level, 0);
      check("rst_ovf", evt_overflow, 0);
      check("rst_id", evt_id, 0);
      check("rst_type", evt_type, 0);
      resetn = 1'b1; chk_en = 1'b1;
      step(2);

      // 1: clean press/release on button 2, with first-event latency
      evt_ready = 1'b1;
      e0 = emitted;
      pb_in[2] = 1'b1;
      n = 0;
      while (emitted == e0 && n < 100) begin @(negedge clk); n++; end
      check("t1_press_seen", emitted - e0, 1);
      check("t1_lat0", evt_valid, 0);
      @(negedge clk); check("t1_lat1", evt_valid, 0);
      @(negedge clk); check("t1_lat2", evt_valid, 1);
      check("t1_id", evt_id, 2);
      @(posedge clk); #1;
      step(25);
      check("t1_level", pb_level[2], 1);
      pb_in[2] = 1'b0;
      step(40);
      check("t1_level_off", pb_level[2], 0);
      drain("t1_drain");

      // 2: bouncing input never qualifies
      e0 = emitted;
      for (int i = 0; i < 20; i++) begin pb_in[0] = ~pb_in[0]; step(3); end
      pb_in[0] = 1'b0;
      step(20);
      check("t2_no_events", emitted - e0, 0);

      // 3: long hold on button 1
      e0 = emitted;
      pb_in[1] = 1'b1;
      step(60);
`ifdef PB_LONGPRESS_EN
      check("t3_events", emitted - e0, 2);
`else
      check("t3_events", emitted - e0, 1);
`endif
      pb_in[1] = 1'b0;
      step(40);
      drain("t3_drain");

      // 4: all buttons at once, consumer stalled
      do_reset();
      pb_in = 4'hF;
      step(30);
      check("t4_valid", evt_valid, 1);
      check("t4_head", evt_id, 0);
      step(3);
      check("t4_valid_held", evt_valid, 1);
      check("t4_head_held", evt_id, 0);
      check("t4_type_held", evt_type, 1);

      // 5: full FIFO, release then re-press button 3 -> overflow
      pb_in[3] = 1'b0;
      step(20);
      pb_in[3] = 1'b1;
      step(20);
      check("t5_ovf", evt_overflow, 1);
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      check("t5_ovf_clr", evt_overflow, 0);
      evt_ready = 1'b1;
      step(20);
      pb_in = '0;
      step(40);
      drain("t5_drain");
      check("t5_count", got_ids.size() >= 4, 1);
      for (int i = 0; i < 4; i++)
         if (got_ids.size() > i) check("t5_order", got_ids[i], i);

      // 6: async reset with events queued
      evt_ready = 1'b0;
      pb_in = 4'b0011;
      step(25);
      check("t6_valid_before", evt_valid, 1);
      @(negedge clk); #2;
      resetn = 1'b0; chk_en = 1'b0;
      #1;
      check("t6_valid_rst", evt_valid, 0);
      check("t6_level_rst", pb_level, 0);
      pb_in = '0;
      @(posedge clk); #1;
      step(2);
      resetn = 1'b1; chk_en = 1'b1;
      step(10);
      check("t6_valid_after", evt_valid, 0);

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NPB; i++)
            if ($urandom_range(0, 15) == 0) pb_in[i] = ~pb_in[i];
         evt_ready = ($urandom_range(0, 3) != 0);
         step(1);
      end
      pb_in = '0;
      evt_ready = 1'b1;
      step(60);
      drain("rand_drain");
      check("final_queue", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
